// File: rtl/image_receiver.sv
// Receive side of the UART pixel link: assembles 5-byte pixel records, checks the
// H/V bytes against local raster counters and emits pixels on a valid/ready port.
`timescale 1ns/1ps
module image_receiver #(
  parameter int WIDTH   = 640,
  parameter int HEIGHT  = 480,
  parameter int TIMEOUT = 50000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  output logic                      rdy,
  output logic                      done,
  input  logic [7:0]                rx_data,
  input  logic                      rx_valid,
  output logic                      pix_valid,
  input  logic                      pix_ready,
  output logic [7:0]                pix_r,
  output logic [7:0]                pix_g,
  output logic [7:0]                pix_b,
  output logic [$clog2(WIDTH)-1:0]  pix_x,
  output logic [$clog2(HEIGHT)-1:0] pix_y,
  output logic                      sync_err,
  output logic                      overrun
);

  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    RDY    = 3'h0,
    WAIT_R = 3'h1,
    WAIT_G = 3'h2,
    WAIT_B = 3'h3,
    WAIT_H = 3'h4,
    WAIT_V = 3'h5,
    EMIT   = 3'h6,
    DONE   = 3'h7
  } state_t;

  state_t          state_q, state_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic [7:0]      r_q, r_d, g_q, g_d, b_q, b_d, h_q, h_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            sync_err_q, sync_err_d;
  logic            overrun_q, overrun_d;
  logic            rdy_q, done_q, pix_valid_q;

  logic            tmo_hit_s, x_last_s, y_last_s, hv_match_s;

  assign tmo_hit_s  = (tmo_q == TW'(TIMEOUT - 1));
  assign x_last_s   = (x_q == XW'(WIDTH - 1));
  assign y_last_s   = (y_q == YW'(HEIGHT - 1));
  // Counters narrower than a byte are zero-extended; wider ones compare their low byte.
  assign hv_match_s = (h_q == 8'(x_q)) && (rx_data == 8'(y_q));

  // Next-state, record assembly, raster counters and sticky flags.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    r_d        = r_q;
    g_d        = g_q;
    b_d        = b_q;
    h_d        = h_q;
    tmo_d      = TW'(0);
    sync_err_d = sync_err_q;
    overrun_d  = overrun_q;

    case (state_q)
      RDY: begin
        sync_err_d = 1'b0;
        overrun_d  = 1'b0;
        if (en) state_d = WAIT_R;
        else    state_d = RDY;
      end
      WAIT_R: begin
        if (!en) begin
          state_d = RDY;
        end else if (rx_valid) begin
          r_d     = rx_data;
          state_d = WAIT_G;
        end else begin
          state_d = WAIT_R;
        end
      end
      WAIT_G, WAIT_B, WAIT_H, WAIT_V: begin
        if (!en) begin
          state_d = RDY;
        end else if (rx_valid) begin
          case (state_q)
            WAIT_G: begin g_d = rx_data; state_d = WAIT_B; end
            WAIT_B: begin b_d = rx_data; state_d = WAIT_H; end
            WAIT_H: begin h_d = rx_data; state_d = WAIT_V; end
            WAIT_V: begin
              if (hv_match_s) begin
                state_d = EMIT;
              end else begin
                sync_err_d = 1'b1;
                state_d    = WAIT_R;
              end
            end
            default: state_d = RDY;
          endcase
        end else if (tmo_hit_s) begin
          sync_err_d = 1'b1;
          state_d    = WAIT_R;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      EMIT: begin
        if (!en) begin
          state_d = RDY;
        end else if (pix_ready) begin
          if (x_last_s) begin
            x_d = XW'(0);
            y_d = y_q + YW'(1);
          end else begin
            x_d = x_q + XW'(1);
          end
          if (x_last_s && y_last_s) begin
            state_d = DONE;
          end else if (rx_valid) begin
            r_d     = rx_data;
            state_d = WAIT_G;
          end else begin
            state_d = WAIT_R;
          end
        end else if (rx_valid) begin
          overrun_d = 1'b1;
        end else begin
          state_d = EMIT;
        end
      end
      DONE: begin
        if (!en) state_d = RDY;
        else     state_d = DONE;
      end
      default: state_d = RDY;
    endcase

    // Raster position restarts whenever capture drops back to idle.
    x_d = (state_d == RDY) ? XW'(0) : x_d;
    y_d = (state_d == RDY) ? YW'(0) : y_d;
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RDY;
      x_q         <= '0;
      y_q         <= '0;
      r_q         <= 8'h00;
      g_q         <= 8'h00;
      b_q         <= 8'h00;
      h_q         <= 8'h00;
      tmo_q       <= '0;
      sync_err_q  <= 1'b0;
      overrun_q   <= 1'b0;
      rdy_q       <= 1'b1;
      done_q      <= 1'b0;
      pix_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      r_q         <= r_d;
      g_q         <= g_d;
      b_q         <= b_d;
      h_q         <= h_d;
      tmo_q       <= tmo_d;
      sync_err_q  <= sync_err_d;
      overrun_q   <= overrun_d;
      rdy_q       <= (state_d == RDY);
      done_q      <= (state_d == DONE);
      pix_valid_q <= (state_d == EMIT);
    end
  end

  assign rdy       = rdy_q;
  assign done      = done_q;
  assign pix_valid = pix_valid_q;
  assign pix_r     = r_q;
  assign pix_g     = g_q;
  assign pix_b     = b_q;
  assign pix_x     = x_q;
  assign pix_y     = y_q;
  assign sync_err  = sync_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_image_receiver.sv
// Scoreboard bench for image_receiver on a 4x2 raster with a 16-cycle byte timeout.
`timescale 1ns/1ps
module tb_image_receiver;

  localparam int W = 4;
  localparam int H = 2;
  localparam int T = 16;

  logic       clk = 1'b0;
  logic       rst, en, rdy, done;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       pix_valid, pix_ready;
  logic [7:0] pix_r, pix_g, pix_b;
  logic [1:0] pix_x;
  logic [0:0] pix_y;
  logic       sync_err, overrun;
  logic [2:0] st;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [1:0] x;
    logic [0:0] y;
  } pix_t;

  pix_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  image_receiver #(.WIDTH(W), .HEIGHT(H), .TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .en(en), .rdy(rdy), .done(done),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .pix_x(pix_x), .pix_y(pix_y),
    .sync_err(sync_err), .overrun(overrun)
  );

  assign st = dut.state_q;

  always #5 clk = ~clk;

  // Scoreboard: every accepted pixel must match the oldest expected record.
  always @(negedge clk) begin
    if (!rst && en && pix_valid && pix_ready) begin
      pix_t obs;
      pix_t exp;
      obs = {pix_r, pix_g, pix_b, pix_x, pix_y};
      total = total + 1;
      if (exp_q.size() == 0) begin
        bad = bad + 1;
        $display("FAIL pix_unexpected got=%h exp=none", obs);
      end else begin
        exp = exp_q.pop_front();
        if (obs !== exp) begin
          bad = bad + 1;
          $display("FAIL pix_data got=%h exp=%h", obs, exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_rec(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                          input logic [7:0] hh, input logic [7:0] vv);
    send_byte(r);
    send_byte(g);
    send_byte(b);
    send_byte(hh);
    send_byte(vv);
  endtask

  task automatic push_pix(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                          input logic [1:0] x, input logic [0:0] y);
    pix_t p;
    p = {r, g, b, x, y};
    exp_q.push_back(p);
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; pix_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    tick();
    total++;
    if ({st, rdy, done, pix_valid, sync_err, overrun} !== {3'h0, 1'b1, 4'b0000}) begin
      bad++;
      $display("FAIL reset_ctrl got=%b exp=%b", {st, rdy, done, pix_valid, sync_err, overrun},
               {3'h0, 1'b1, 4'b0000});
    end
    total++;
    if ({pix_r, pix_g, pix_b, pix_x, pix_y} !== 27'd0) begin
      bad++;
      $display("FAIL reset_data got=%h exp=0", {pix_r, pix_g, pix_b, pix_x, pix_y});
    end
  endtask

  task automatic test_normal_frame();
    do_reset();
    en = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      push_pix(8'(i), 8'(i + 1), 8'(i + 2), 2'(i % 4), 1'(i / 4));
      send_rec(8'(i), 8'(i + 1), 8'(i + 2), 8'(i % 4), 8'(i / 4));
    end
    tick();
    total++;
    if ({st, done, rdy, sync_err, overrun} !== {3'h7, 1'b1, 3'b000}) begin
      bad++;
      $display("FAIL frame_done got=%b exp=%b", {st, done, rdy, sync_err, overrun},
               {3'h7, 1'b1, 3'b000});
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL frame_pending got=%0d exp=0", exp_q.size());
    end
    en = 1'b0;
    tick();
    total++;
    if ({st, rdy, done} !== {3'h0, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL frame_to_rdy got=%b exp=%b", {st, rdy, done}, {3'h0, 1'b1, 1'b0});
    end
  endtask

  task automatic test_latency_walk();
    logic [7:0] bs [5];
    bs = '{8'hA0, 8'hA1, 8'hA2, 8'h00, 8'h00};
    do_reset();
    en = 1'b1;
    tick();
    push_pix(8'hA0, 8'hA1, 8'hA2, 2'd0, 1'd0);
    for (int k = 0; k < 5; k++) begin
      if (k == 4) begin
        total++;
        if (pix_valid !== 1'b0) begin
          bad++;
          $display("FAIL walk_early_valid got=%b exp=0", pix_valid);
        end
      end
      send_byte(bs[k]);
      total++;
      if (st !== 3'(k + 2)) begin
        bad++;
        $display("FAIL walk_state got=%0d exp=%0d", st, k + 2);
      end
      if (k == 4) begin
        total++;
        if (pix_valid !== 1'b1) begin
          bad++;
          $display("FAIL walk_latency got=%b exp=1", pix_valid);
        end
      end else begin
        tick();
        tick();
        total++;
        if (st !== 3'(k + 2)) begin
          bad++;
          $display("FAIL walk_hold got=%0d exp=%0d", st, k + 2);
        end
      end
    end
    tick();
    total++;
    if (st !== 3'h1 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL walk_after got=%0d/%0d exp=1/0", st, exp_q.size());
    end
  endtask

  task automatic test_mismatch();
    do_reset();
    en = 1'b1;
    tick();
    push_pix(8'h10, 8'h11, 8'h12, 2'd0, 1'd0);
    send_rec(8'h10, 8'h11, 8'h12, 8'h00, 8'h00);
    send_rec(8'h20, 8'h21, 8'h22, 8'h03, 8'h00);
    total++;
    if ({sync_err, st, pix_x, pix_valid} !== {1'b1, 3'h1, 2'd1, 1'b0}) begin
      bad++;
      $display("FAIL mismatch got=%b exp=%b", {sync_err, st, pix_x, pix_valid},
               {1'b1, 3'h1, 2'd1, 1'b0});
    end
    push_pix(8'h30, 8'h31, 8'h32, 2'd1, 1'd0);
    send_rec(8'h30, 8'h31, 8'h32, 8'h01, 8'h00);
    tick();
    total++;
    if (exp_q.size() != 0 || pix_x !== 2'd2) begin
      bad++;
      $display("FAIL mismatch_recover got=%0d/%0d exp=0/2", exp_q.size(), pix_x);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    en = 1'b1;
    tick();
    send_byte(8'h40);
    send_byte(8'h41);
    repeat (T - 1) tick();
    total++;
    if ({st, sync_err} !== {3'h3, 1'b0}) begin
      bad++;
      $display("FAIL timeout_early got=%b exp=%b", {st, sync_err}, {3'h3, 1'b0});
    end
    tick();
    total++;
    if ({st, sync_err} !== {3'h1, 1'b1}) begin
      bad++;
      $display("FAIL timeout_fire got=%b exp=%b", {st, sync_err}, {3'h1, 1'b1});
    end
    push_pix(8'h50, 8'h51, 8'h52, 2'd0, 1'd0);
    send_rec(8'h50, 8'h51, 8'h52, 8'h00, 8'h00);
    tick();
    total++;
    if (exp_q.size() != 0 || sync_err !== 1'b1) begin
      bad++;
      $display("FAIL timeout_recover got=%0d/%b exp=0/1", exp_q.size(), sync_err);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    en = 1'b1;
    tick();
    pix_ready = 1'b0;
    push_pix(8'h60, 8'h61, 8'h62, 2'd0, 1'd0);
    send_rec(8'h60, 8'h61, 8'h62, 8'h00, 8'h00);
    tick();
    total++;
    if ({pix_valid, pix_r, pix_g, pix_b, pix_x} !== {1'b1, 24'h606162, 2'd0}) begin
      bad++;
      $display("FAIL bp_hold1 got=%h exp=%h", {pix_valid, pix_r, pix_g, pix_b, pix_x},
               {1'b1, 24'h606162, 2'd0});
    end
    send_byte(8'h55);
    total++;
    if ({overrun, st, pix_valid, pix_r} !== {1'b1, 3'h6, 1'b1, 8'h60}) begin
      bad++;
      $display("FAIL bp_overrun got=%h exp=%h", {overrun, st, pix_valid, pix_r},
               {1'b1, 3'h6, 1'b1, 8'h60});
    end
    tick();
    total++;
    if ({pix_valid, pix_r, pix_g, pix_b, pix_x} !== {1'b1, 24'h606162, 2'd0}) begin
      bad++;
      $display("FAIL bp_hold3 got=%h exp=%h", {pix_valid, pix_r, pix_g, pix_b, pix_x},
               {1'b1, 24'h606162, 2'd0});
    end
    pix_ready = 1'b1;
    push_pix(8'h77, 8'h78, 8'h79, 2'd1, 1'd0);
    send_byte(8'h77);
    total++;
    if ({st, overrun} !== {3'h2, 1'b1}) begin
      bad++;
      $display("FAIL bp_take_r got=%b exp=%b", {st, overrun}, {3'h2, 1'b1});
    end
    send_byte(8'h78);
    send_byte(8'h79);
    send_byte(8'h01);
    send_byte(8'h00);
    tick();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL bp_pending got=%0d exp=0", exp_q.size());
    end
  endtask

  task automatic test_abort_reset();
    do_reset();
    en = 1'b1;
    tick();
    send_byte(8'h90);
    send_byte(8'h91);
    en = 1'b0;
    tick();
    total++;
    if ({st, rdy, pix_valid} !== {3'h0, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL abort got=%b exp=%b", {st, rdy, pix_valid}, {3'h0, 1'b1, 1'b0});
    end
    en = 1'b1;
    tick();
    pix_ready = 1'b0;
    send_rec(8'h11, 8'h22, 8'h33, 8'h00, 8'h00);
    total++;
    if ({st, pix_valid} !== {3'h6, 1'b1}) begin
      bad++;
      $display("FAIL abort_reemit got=%b exp=%b", {st, pix_valid}, {3'h6, 1'b1});
    end
    rst = 1'b1;
    tick();
    total++;
    if ({pix_valid, rdy, st} !== {1'b0, 1'b1, 3'h0}) begin
      bad++;
      $display("FAIL rst_emit got=%b exp=%b", {pix_valid, rdy, st}, {1'b0, 1'b1, 3'h0});
    end
    rst = 1'b0;
    pix_ready = 1'b1;
    en = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_normal_frame();
    test_latency_walk();
    test_mismatch();
    test_timeout();
    test_backpressure();
    test_abort_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
